// File: rtl/mir_skid.sv
// mir_skid: falling-edge microinstruction register with valid/ready, 2-entry skid buffer, flush and stall counter.
// Optional MIR_PARITY_EN adds even-parity checking of accepted microwords (uins_par in, sticky par_err out).
module mir_skid #(
   parameter int ADDR_W = 5,
   parameter int M_W    = 3,
   parameter int COND_W = 1,
   parameter int CNT_W  = 16,
   parameter int UINS_W = COND_W + 1 + ADDR_W + 2 * M_W
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              flush,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [UINS_W-1:0] uins,
`ifdef MIR_PARITY_EN
   input  logic              uins_par,
   output logic              par_err,
`endif
   output logic              out_valid,
   input  logic              out_ready,
   output logic [ADDR_W-1:0] addr,
   output logic [M_W-1:0]    m1,
   output logic [M_W-1:0]    m2,
   output logic              bt,
   output logic [COND_W-1:0] cond_sel,
   output logic [CNT_W-1:0]  stall_cnt
);
   logic [UINS_W-1:0] head, skid, head_n, skid_n, word;
   logic [1:0]        occ, occ_n;
   logic              acc, pop;

   assign out_valid = occ != 2'd0;
   assign in_ready  = occ != 2'd2;
   assign acc       = in_valid & in_ready & ~flush;
   assign pop       = out_valid & out_ready & ~flush;
   // an empty buffer presents an all-zero NOP microword
   assign {cond_sel, bt, addr, m1, m2} = out_valid ? head : '0;

`ifdef MIR_PARITY_EN
   logic bad;
   assign bad  = ^{uins, uins_par};
   assign word = bad ? '0 : uins;
   always_ff @(negedge clk or negedge rst_n)
      if (!rst_n) par_err <= 1'b0;
      else if (acc && bad) par_err <= 1'b1;
`else
   assign word = uins;
`endif

   always_comb begin
      head_n = head;
      skid_n = skid;
      occ_n  = occ;
      if (flush) occ_n = 2'd0;
      else if (occ == 2'd0) begin
         if (acc) begin
            head_n = word;
            occ_n  = 2'd1;
         end
      end else if (occ == 2'd1) begin
         if (acc && pop) head_n = word;
         else if (acc) begin
            skid_n = word;
            occ_n  = 2'd2;
         end else if (pop) occ_n = 2'd0;
      end else if (pop) begin
         head_n = skid;
         occ_n  = 2'd1;
      end
   end

   always_ff @(negedge clk or negedge rst_n)
      if (!rst_n) begin
         head      <= '0;
         skid      <= '0;
         occ       <= 2'd0;
         stall_cnt <= '0;
      end else begin
         head <= head_n;
         skid <= skid_n;
         occ  <= occ_n;
         if (out_valid && !out_ready && stall_cnt != '1) stall_cnt <= stall_cnt + 1'b1;
      end
endmodule

// File: tb/tb_mir_skid.sv
// tb_mir_skid: scoreboard bench for mir_skid; a queue models buffer contents and stall count.
module tb_mir_skid;
   logic        clk = 1'b0, rst_n = 1'b0, flush = 1'b0, in_valid = 1'b0, out_ready = 1'b0;
   logic [12:0] uins = '0;
   logic        in_ready, out_valid, bt;
   logic [4:0]  addr;
   logic [2:0]  m1, m2;
   logic [0:0]  cond_sel;
   logic [15:0] stall_cnt, stall_exp = '0;
   logic [12:0] q[$];
   int          n_chk = 0, n_err = 0;
`ifdef MIR_PARITY_EN
   logic        uins_par = 1'b0, par_err, perr_exp = 1'b0;
`endif

   mir_skid dut (
      .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
      .uins(uins),
`ifdef MIR_PARITY_EN
      .uins_par(uins_par), .par_err(par_err),
`endif
      .out_valid(out_valid), .out_ready(out_ready), .addr(addr), .m1(m1), .m2(m2),
      .bt(bt), .cond_sel(cond_sel), .stall_cnt(stall_cnt)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // called at a posedge: compare against the model, drive inputs, advance model across the next negedge
   task automatic cyc(input logic iv, input logic [12:0] w, input logic ordy, input logic fl,
                      input logic bad = 1'b0);
      int n;
      check("out_valid", out_valid, q.size() != 0);
      check("in_ready", in_ready, q.size() < 2);
      check("fields", {cond_sel, bt, addr, m1, m2}, q.size() != 0 ? q[0] : 13'h0);
      check("stall_cnt", stall_cnt, stall_exp);
`ifdef MIR_PARITY_EN
      check("par_err", par_err, perr_exp);
      uins_par = ^w ^ bad;
`endif
      in_valid = iv; uins = w; out_ready = ordy; flush = fl;
      if (q.size() != 0 && !ordy && stall_exp != 16'hFFFF) stall_exp++;
      if (fl) q.delete();
      else begin
         n = q.size();
         if (n != 0 && ordy) void'(q.pop_front());
         if (iv && n < 2) begin
            q.push_back(bad ? 13'h0 : w);
`ifdef MIR_PARITY_EN
            if (bad) perr_exp = 1'b1;
`endif
         end
      end
      @(posedge clk);
   endtask

   initial begin
      #1;
      check("rst_valid", out_valid, 0);
      check("rst_ready", in_ready, 1);
      check("rst_fields", {cond_sel, bt, addr, m1, m2}, 0);
      check("rst_stall", stall_cnt, 0);
      #1 rst_n = 1'b1;
      @(posedge clk);
      cyc(1, 13'h1A5B, 1, 0);
      check("t1_cond", cond_sel, 1);
      check("t1_bt", bt, 1);
      check("t1_addr", addr, 5'h09);
      check("t1_m1", m1, 3);
      check("t1_m2", m2, 3);
      cyc(0, 0, 1, 0);
      // fill with consumer stalled, then drain in order
      cyc(1, 13'h0111, 0, 0);
      cyc(1, 13'h0222, 0, 0);
      cyc(1, 13'h0333, 0, 0);
      cyc(0, 0, 1, 0);
      cyc(0, 0, 1, 0);
      cyc(0, 0, 1, 0);
      // occupancy 1 with simultaneous accept and pop
      cyc(1, 13'h0AAA, 0, 0);
      cyc(1, 13'h0555, 1, 0);
      cyc(0, 0, 0, 0);
      cyc(0, 0, 1, 0);
      // full buffer flushed while a word is offered
      cyc(1, 13'h1111, 0, 0);
      cyc(1, 13'h1222, 0, 0);
      cyc(1, 13'h1333, 0, 1);
      cyc(0, 0, 0, 0);
      for (int i = 0; i < 400; i++)
         cyc($urandom_range(0, 1), 13'($urandom), $urandom_range(0, 1), $urandom_range(0, 15) == 0);
      // asynchronous reset between edges
      cyc(1, 13'h0F0F, 0, 0);
      cyc(1, 13'h10F0, 0, 0);
      in_valid = 1'b0; out_ready = 1'b0; flush = 1'b0;
      #2 rst_n = 1'b0;
      #1;
      check("arst_valid", out_valid, 0);
      check("arst_ready", in_ready, 1);
      check("arst_fields", {cond_sel, bt, addr, m1, m2}, 0);
      check("arst_stall", stall_cnt, 0);
      q.delete();
      stall_exp = '0;
      #1 rst_n = 1'b1;
      @(posedge clk);
`ifdef MIR_PARITY_EN
      cyc(1, 13'h1A5B, 0, 0, 1);
      cyc(0, 0, 1, 0);
      cyc(1, 13'h0123, 1, 0);
      cyc(0, 0, 1, 0);
`endif
      // long stall saturates the counter
      cyc(1, 13'h0777, 0, 0);
      for (int i = 0; i < 70000; i++) cyc(0, 0, 0, 0);
      check("stall_sat", stall_cnt, 16'hFFFF);
      cyc(0, 0, 1, 0);
      cyc(0, 0, 0, 0);
      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end
endmodule
